// File: rtl/controlador_interrupciones_pkg.sv
// Shared definitions for the interrupt controller: register offsets, CTRL bits,
// timer state encoding and source numbering.
package cpu_defs;

    localparam int unsigned N_EXT     = 7;
    localparam int unsigned N_SRC     = 8;
    localparam int unsigned TIMER_SRC = 7;

    localparam logic [2:0] OFF_PEND   = 3'd0;
    localparam logic [2:0] OFF_MASK   = 3'd1;
    localparam logic [2:0] OFF_RELOAD = 3'd2;
    localparam logic [2:0] OFF_COUNT  = 3'd3;
    localparam logic [2:0] OFF_CTRL   = 3'd4;

    localparam int unsigned CTRL_EN   = 0;
    localparam int unsigned CTRL_AUTO = 1;

    typedef struct packed {
        logic auto_rl;
        logic en;
    } ctrl_t;

    typedef enum logic {
        T_IDLE   = 1'b0,
        T_CUENTA = 1'b1
    } estado_t;

endpackage

// File: rtl/controlador_interrupciones_temporizador.sv
// Countdown timer: RELOAD/COUNT/CTRL registers, IDLE/CUENTA FSM and a registered
// one-cycle disparo pulse that is high during the cycle COUNT==1.
module temporizador
    import cpu_defs::*;
#(
    parameter int unsigned ANCHO = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_reload,
    input  logic             wr_ctrl,
    input  logic [ANCHO-1:0] wdata,
    output logic [ANCHO-1:0] reload,
    output logic [ANCHO-1:0] count,
    output ctrl_t            ctrl,
    output logic             disparo
);

    estado_t          estado, estado_n;
    logic [ANCHO-1:0] reload_n, count_n;
    ctrl_t            ctrl_n;
    logic             disparo_n;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            estado  <= T_IDLE;
            reload  <= '0;
            count   <= '0;
            ctrl    <= '0;
            disparo <= 1'b0;
        end else begin
            estado  <= estado_n;
            reload  <= reload_n;
            count   <= count_n;
            ctrl    <= ctrl_n;
            disparo <= disparo_n;
        end
    end

    // Bus writes are folded in first so the FSM reacts at the write edge itself.
    always_comb begin
        estado_n  = estado;
        reload_n  = reload;
        count_n   = count;
        ctrl_n    = ctrl;
        disparo_n = 1'b0;

        if (wr_reload) begin
            reload_n = wdata;
            count_n  = wdata;
        end
        if (wr_ctrl) begin
            ctrl_n.en      = wdata[CTRL_EN];
            ctrl_n.auto_rl = wdata[CTRL_AUTO];
        end

        case (estado)
            T_IDLE: begin
                if (ctrl_n.en && (reload_n != '0)) begin
                    estado_n = T_CUENTA;
                    count_n  = reload_n;
                end
            end
            T_CUENTA: begin
                if (!ctrl_n.en) begin
                    estado_n = T_IDLE;
                end else if (wr_reload) begin
                    if (wdata == '0) estado_n = T_IDLE;
                end else if (count == ANCHO'(1)) begin
                    if (ctrl_n.auto_rl) begin
                        count_n = reload;
                    end else begin
                        count_n   = '0;
                        ctrl_n.en = 1'b0;
                        estado_n  = T_IDLE;
                    end
                end else if (count == '0) begin
                    estado_n = T_IDLE;
                end else begin
                    count_n = count - ANCHO'(1);
                end
            end
            default: estado_n = T_IDLE;
        endcase

        // Look ahead one edge so the pulse lines up with COUNT==1.
        disparo_n = (estado_n == T_CUENTA) && (count_n == ANCHO'(1));
    end

endmodule

// File: rtl/controlador_interrupciones.sv
// Memory-mapped interrupt controller: synchronised edge detection of external
// events plus a timer source, pending/mask registers and the CPU read/write window.
module controlador_interrupciones
    import cpu_defs::*;
#(
    parameter int unsigned     ANCHO    = 16,
    parameter logic [ANCHO-1:0] DIR_BASE = 16'hFF00
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [ANCHO-1:0] direcciones,
    input  logic [ANCHO-1:0] datos_in,
    input  logic             we,
    input  logic             re,
    output logic [ANCHO-1:0] datos_out,
    output logic             sel,
    input  logic [N_EXT-1:0] eventos,
    output logic [N_SRC-1:0] interrupcion
);

    logic [ANCHO-1:0] off;
    logic             wr_en, wr_pend, wr_mask, wr_reload, wr_ctrl;
    logic [N_EXT-1:0] sync1, sync2, prev, rise;
    logic [N_SRC-1:0] pend, pend_n, mask, set_v, clr_v;
    logic [ANCHO-1:0] reload, count;
    ctrl_t            ctrl;
    logic             disparo;

    // Unsigned wrap makes addresses below the base fall outside the window too.
    assign off       = direcciones - DIR_BASE;
    assign sel       = (off < ANCHO'(8));
    assign wr_en     = we && sel;
    assign wr_pend   = wr_en && (off[2:0] == OFF_PEND);
    assign wr_mask   = wr_en && (off[2:0] == OFF_MASK);
    assign wr_reload = wr_en && (off[2:0] == OFF_RELOAD);
    assign wr_ctrl   = wr_en && (off[2:0] == OFF_CTRL);

    temporizador #(.ANCHO(ANCHO)) u_temporizador (
        .clk       (clk),
        .rst_n     (reset),
        .wr_reload (wr_reload),
        .wr_ctrl   (wr_ctrl),
        .wdata     (datos_in),
        .reload    (reload),
        .count     (count),
        .ctrl      (ctrl),
        .disparo   (disparo)
    );

    assign rise = sync2 & ~prev;

    // Set has priority over a write-1-to-clear on the same bit.
    always_comb begin
        set_v            = {1'b0, rise};
        set_v[TIMER_SRC] = disparo;
        clr_v            = wr_pend ? datos_in[N_SRC-1:0] : '0;
        pend_n           = (pend & ~clr_v) | set_v;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1        <= '0;
            sync2        <= '0;
            prev         <= '0;
            pend         <= '0;
            mask         <= '0;
            interrupcion <= '0;
        end else begin
            sync1        <= eventos;
            sync2        <= sync1;
            prev         <= sync2;
            pend         <= pend_n;
            if (wr_mask) mask <= datos_in[N_SRC-1:0];
            interrupcion <= pend & mask;
        end
    end

    always_comb begin
        datos_out = '0;
        if (re && sel) begin
            case (off[2:0])
                OFF_PEND:   datos_out = ANCHO'(pend);
                OFF_MASK:   datos_out = ANCHO'(mask);
                OFF_RELOAD: datos_out = reload;
                OFF_COUNT:  datos_out = count;
                OFF_CTRL:   datos_out = ANCHO'(ctrl);
                default:    datos_out = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_controlador_interrupciones.sv
// Directed self-checking bench for controlador_interrupciones: a register-map
// vector table plus hand-written multi-cycle sequences.
module tb_controlador_interrupciones;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] direcciones, datos_in, datos_out;
    logic        we, re, sel;
    logic [6:0]  eventos;
    logic [7:0]  interrupcion;

    int checks   = 0;
    int failures = 0;

    controlador_interrupciones dut (
        .clk          (clk),
        .reset        (reset),
        .direcciones  (direcciones),
        .datos_in     (datos_in),
        .we           (we),
        .re           (re),
        .datos_out    (datos_out),
        .sel          (sel),
        .eventos      (eventos),
        .interrupcion (interrupcion)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          wr;
        logic [15:0] addr;
        logic [15:0] data;
        bit          rd_en;
        logic [15:0] exp;
        bit          exp_sel;
    } vec_t;

    vec_t vt[16];

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic wr(input logic [15:0] a, input logic [15:0] d);
        direcciones = a;
        datos_in    = d;
        we          = 1'b1;
        tick();
        we          = 1'b0;
    endtask

    task automatic rd(input logic [15:0] a, output logic [15:0] v);
        direcciones = a;
        re          = 1'b1;
        #1;
        v           = datos_out;
        re          = 1'b0;
    endtask

    task automatic rd_chk(input string nm, input logic [15:0] a, input logic [15:0] exp);
        logic [15:0] v;
        rd(a, v);
        chk(nm, v, exp);
    endtask

    initial begin
        logic [15:0] v;
        logic [7:0]  fired;

        vt[0]  = '{1'b1, 16'hFF01, 16'hFFA5, 1'b0, 16'h0000, 1'b0};
        vt[1]  = '{1'b0, 16'hFF01, 16'h0000, 1'b1, 16'h00A5, 1'b1};
        vt[2]  = '{1'b1, 16'hFF02, 16'h1234, 1'b0, 16'h0000, 1'b0};
        vt[3]  = '{1'b0, 16'hFF02, 16'h0000, 1'b1, 16'h1234, 1'b1};
        vt[4]  = '{1'b0, 16'hFF03, 16'h0000, 1'b1, 16'h1234, 1'b1};
        vt[5]  = '{1'b1, 16'hFF04, 16'hFFFE, 1'b0, 16'h0000, 1'b0};
        vt[6]  = '{1'b0, 16'hFF04, 16'h0000, 1'b1, 16'h0002, 1'b1};
        vt[7]  = '{1'b1, 16'hFF05, 16'hBEEF, 1'b0, 16'h0000, 1'b0};
        vt[8]  = '{1'b0, 16'hFF05, 16'h0000, 1'b1, 16'h0000, 1'b1};
        vt[9]  = '{1'b0, 16'hFF07, 16'h0000, 1'b1, 16'h0000, 1'b1};
        vt[10] = '{1'b0, 16'hFF08, 16'h0000, 1'b1, 16'h0000, 1'b0};
        vt[11] = '{1'b0, 16'hFEFF, 16'h0000, 1'b1, 16'h0000, 1'b0};
        vt[12] = '{1'b0, 16'hFF01, 16'h0000, 1'b0, 16'h0000, 1'b1};
        vt[13] = '{1'b1, 16'hFF03, 16'h5555, 1'b0, 16'h0000, 1'b0};
        vt[14] = '{1'b0, 16'hFF03, 16'h0000, 1'b1, 16'h1234, 1'b1};
        vt[15] = '{1'b0, 16'hFF00, 16'h0000, 1'b1, 16'h0000, 1'b1};

        reset = 1'b0; eventos = 7'h7F; we = 1'b0; re = 1'b0;
        direcciones = 16'h0000; datos_in = 16'h0000;

        // Reset with all event lines high
        tick(3);
        chk("irq_in_reset", {8'h00, interrupcion}, 16'h0000);
        rd_chk("pend_in_reset", 16'hFF00, 16'h0000);
        eventos = 7'h00;
        reset   = 1'b1;
        tick(2);
        for (int i = 0; i < 5; i++)
            rd_chk($sformatf("reset_off%0d", i), 16'hFF00 + 16'(i), 16'h0000);
        chk("irq_after_reset", {8'h00, interrupcion}, 16'h0000);

        // Register map table
        for (int i = 0; i < 16; i++) begin
            if (vt[i].wr) begin
                wr(vt[i].addr, vt[i].data);
            end else begin
                direcciones = vt[i].addr;
                re          = vt[i].rd_en;
                #1;
                chk($sformatf("vec%0d_data", i), datos_out, vt[i].exp);
                chk($sformatf("vec%0d_sel", i), {15'h0, sel}, {15'h0, vt[i].exp_sel});
                re = 1'b0;
            end
        end
        wr(16'hFF04, 16'h0000);
        wr(16'hFF02, 16'h0000);

        // Edge detection and masking
        wr(16'hFF01, 16'h0005);
        eventos = 7'h03;
        tick();
        eventos = 7'h00;
        tick();
        chk("irq_edge_n1", {8'h00, interrupcion}, 16'h0000);
        tick();
        rd_chk("pend_edge_n2", 16'hFF00, 16'h0003);
        chk("irq_edge_n2", {8'h00, interrupcion}, 16'h0000);
        tick();
        chk("irq_edge_n3", {8'h00, interrupcion}, 16'h0001);
        wr(16'hFF00, 16'h0001);
        rd_chk("pend_after_clr", 16'hFF00, 16'h0002);
        chk("irq_clr_m", {8'h00, interrupcion}, 16'h0001);
        tick();
        chk("irq_clr_m1", {8'h00, interrupcion}, 16'h0000);
        wr(16'hFF00, 16'h0002);

        // Held level must not re-trigger
        eventos = 7'h04;
        tick(3);
        rd_chk("lvl_first", 16'hFF00, 16'h0004);
        tick(5);
        wr(16'hFF00, 16'h0004);
        rd_chk("lvl_cleared", 16'hFF00, 16'h0000);
        tick(11);
        rd_chk("lvl_held", 16'hFF00, 16'h0000);
        eventos = 7'h00;
        tick(4);
        rd_chk("lvl_fall", 16'hFF00, 16'h0000);
        eventos = 7'h04;
        tick(3);
        rd_chk("lvl_rerise", 16'hFF00, 16'h0004);
        eventos = 7'h00;
        wr(16'hFF00, 16'h0004);

        // One-shot timer, RELOAD=5
        wr(16'hFF01, 16'h0080);
        wr(16'hFF02, 16'h0005);
        wr(16'hFF04, 16'h0001);
        rd_chk("os_count_m", 16'hFF03, 16'h0005);
        tick(4);
        rd_chk("os_pend_m4", 16'hFF00, 16'h0000);
        rd_chk("os_count_m4", 16'hFF03, 16'h0001);
        tick();
        rd_chk("os_pend_m5", 16'hFF00, 16'h0080);
        rd_chk("os_ctrl", 16'hFF04, 16'h0000);
        rd_chk("os_count_done", 16'hFF03, 16'h0000);
        chk("os_irq_m5", {8'h00, interrupcion}, 16'h0000);
        tick();
        chk("os_irq_m6", {8'h00, interrupcion}, 16'h0080);
        wr(16'hFF00, 16'h0080);
        chk("os_irq_clr", {8'h00, interrupcion}, 16'h0080);
        tick();
        chk("os_irq_clr1", {8'h00, interrupcion}, 16'h0000);
        tick(10);
        rd_chk("os_no_refire", 16'hFF00, 16'h0000);
        rd_chk("os_count_idle", 16'hFF03, 16'h0000);

        // Auto-reload timer, RELOAD=3
        wr(16'hFF02, 16'h0003);
        wr(16'hFF04, 16'h0003);
        tick(2);
        rd_chk("ar_pend_m2", 16'hFF00, 16'h0000);
        tick();
        rd_chk("ar_pend_m3", 16'hFF00, 16'h0080);
        wr(16'hFF00, 16'h0080);
        rd_chk("ar_pend_m4", 16'hFF00, 16'h0000);
        tick();
        rd_chk("ar_pend_m5", 16'hFF00, 16'h0000);
        rd_chk("ar_count_m5", 16'hFF03, 16'h0001);
        wr(16'hFF00, 16'h0080);
        rd_chk("ar_set_wins", 16'hFF00, 16'h0080);
        wr(16'hFF00, 16'h0080);
        rd_chk("ar_pend_m7", 16'hFF00, 16'h0000);
        tick(2);
        rd_chk("ar_pend_m9", 16'hFF00, 16'h0080);
        wr(16'hFF04, 16'h0000);
        rd_chk("ar_ctrl_off", 16'hFF04, 16'h0000);
        rd_chk("ar_count_frozen", 16'hFF03, 16'h0003);
        wr(16'hFF00, 16'h0080);
        tick(6);
        rd_chk("ar_stopped_pend", 16'hFF00, 16'h0000);
        rd_chk("ar_stopped_count", 16'hFF03, 16'h0003);

        // Reset in the middle of an auto-reload count
        wr(16'hFF02, 16'd100);
        wr(16'hFF04, 16'h0003);
        tick(60);
        rd_chk("rst_count40", 16'hFF03, 16'd40);
        reset = 1'b0;
        #1;
        rd_chk("rst_async_count", 16'hFF03, 16'h0000);
        chk("rst_async_irq", {8'h00, interrupcion}, 16'h0000);
        tick(2);
        reset = 1'b1;
        tick();
        rd_chk("rst_count", 16'hFF03, 16'h0000);
        rd_chk("rst_ctrl", 16'hFF04, 16'h0000);
        rd_chk("rst_reload", 16'hFF02, 16'h0000);
        rd_chk("rst_mask", 16'hFF01, 16'h0000);
        fired = 8'h00;
        for (int i = 0; i < 200; i++) begin
            rd(16'hFF00, v);
            fired = fired | v[7:0];
            tick();
        end
        chk("rst_no_fire", {8'h00, fired}, 16'h0000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
